// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and default sizes for the data-memory arbiter
package dmem_arb_pkg;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 9;
  localparam int DMEM_MAX_WAIT = 4;
  localparam logic [DMEM_ADDR_W-1:0] DMEM_AUX_BASE = 9'h100;
  localparam logic [DMEM_ADDR_W-1:0] DMEM_AUX_LIMIT = 9'h1FF;
  typedef enum logic {OWNER_CORE, OWNER_AUX} owner_e;
  typedef struct packed {
    logic we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/aux data-memory arbiter with starvation guard; DMEM_ARB_BOUNDS_EN adds an aux address window check
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int MAX_WAIT = DMEM_MAX_WAIT,
  parameter logic [ADDR_W-1:0] AUX_BASE = ADDR_W'(DMEM_AUX_BASE),
  parameter logic [ADDR_W-1:0] AUX_LIMIT = ADDR_W'(DMEM_AUX_LIMIT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);
`ifdef DMEM_ARB_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam int WW = $clog2(MAX_WAIT + 2);
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic rsp_pending_q, rsp_pending_d;
  owner_e rsp_owner_q, rsp_owner_d;
  logic rsp_err_q, rsp_err_d;
  logic a_err_q, a_err_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d, a_rdata_q, a_rdata_d;
  logic starve, a_oob, mem_go, win_we;
  // Arbitration, memory drive and read-return steering
  always_comb begin
    starve = wait_cnt_q == WW'(MAX_WAIT);
    a_gnt = a_req & (~c_req | starve);
    c_gnt = c_req & ~a_gnt;
    c_stall = c_req & ~c_gnt;
    a_oob = BOUNDS_EN & ((a_addr < AUX_BASE) | (a_addr > AUX_LIMIT));
    win_we = a_gnt ? a_we : c_we;
    mem_go = c_gnt | (a_gnt & ~a_oob);
    mem_wr = mem_go & win_we;
    mem_rd = mem_go & ~win_we;
    mem_addr = mem_go ? (a_gnt ? a_addr : c_addr) : '0;
    mem_wr_data = mem_go ? (a_gnt ? a_wdata : c_wdata) : '0;
    wait_cnt_d = (a_req & ~a_gnt) ? wait_cnt_q + WW'(1) : '0;
    rsp_pending_d = (c_gnt & ~c_we) | (a_gnt & ~a_we);
    rsp_owner_d = a_gnt ? OWNER_AUX : OWNER_CORE;
    rsp_err_d = a_gnt & a_oob & ~a_we;
    a_err_d = a_gnt & a_oob;
    c_rvalid = rsp_pending_q & (rsp_owner_q == OWNER_CORE);
    a_rvalid = rsp_pending_q & (rsp_owner_q == OWNER_AUX);
    c_rdata_d = c_rvalid ? mem_rd_data : c_rdata_q;
    a_rdata_d = a_rvalid ? (rsp_err_q ? '0 : mem_rd_data) : a_rdata_q;
    c_rdata = c_rdata_d;
    a_rdata = a_rdata_d;
    a_err = a_err_q;
  end
  // Starvation counter, outstanding-read tag and held read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      rsp_pending_q <= 1'b0;
      rsp_owner_q <= OWNER_CORE;
      rsp_err_q <= 1'b0;
      a_err_q <= 1'b0;
      c_rdata_q <= '0;
      a_rdata_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_err_q <= rsp_err_d;
      a_err_q <= a_err_d;
      c_rdata_q <= c_rdata_d;
      a_rdata_q <= a_rdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a synchronous memory model
module tb_dmem_arbiter;
  logic clk = 0, reset = 0;
  logic c_req = 0, c_we = 0, a_req = 0, a_we = 0;
  logic [8:0] c_addr = 0, a_addr = 0;
  logic [31:0] c_wdata = 0, a_wdata = 0;
  logic c_gnt, c_stall, c_rvalid, a_gnt, a_rvalid, a_err, mem_wr, mem_rd;
  logic [31:0] c_rdata, a_rdata, mem_wr_data, mem_rd_data;
  logic [8:0] mem_addr;
  logic [31:0] mem [512];
  logic wrv [512];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );
  // Unwritten words read back as A5A5_0xxx with xxx the address
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) wrv[i] <= 1'b0;
      mem_rd_data <= '0;
    end else begin
      if (mem_wr) begin
        mem[mem_addr] <= mem_wr_data;
        wrv[mem_addr] <= 1'b1;
      end
      if (mem_rd) mem_rd_data <= wrv[mem_addr] ? mem[mem_addr] : {16'hA5A5, 7'b0, mem_addr};
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_gnt", {c_gnt, a_gnt, mem_wr, mem_rd}, 0);
    tick; tick;
    reset = 1;
    @(negedge clk);
    chk("idle_mem", {mem_wr, mem_rd, 23'(mem_addr)}, 0);
    tick;
    c_req = 1; c_we = 1; c_addr = 9'h010; c_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("c_wr_gnt", c_gnt, 1);
    chk("c_wr_stall", c_stall, 0);
    chk("c_wr_memwr", mem_wr, 1);
    chk("c_wr_data", mem_wr_data, 32'hDEADBEEF);
    tick;
    c_we = 0;
    @(negedge clk);
    chk("c_rd_gnt", c_gnt, 1);
    chk("c_rd_stall", c_stall, 0);
    chk("c_rd_memrd", mem_rd, 1);
    tick;
    c_req = 0;
    @(negedge clk);
    chk("c_rvalid", c_rvalid, 1);
    chk("c_rdata", c_rdata, 32'hDEADBEEF);
    tick;
    @(negedge clk);
    chk("c_rvalid_drop", c_rvalid, 0);
    chk("c_rdata_hold", c_rdata, 32'hDEADBEEF);
    tick;
    c_req = 1; c_we = 0; c_addr = 9'h003;
    a_req = 1; a_we = 0; a_addr = 9'h120;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("cont_lose%0d", i), {c_gnt, a_gnt, c_stall}, 3'b100);
      tick;
    end
    @(negedge clk);
    chk("cont_win", {c_gnt, a_gnt, c_stall, mem_rd}, 4'b0111);
    chk("cont_addr", mem_addr, 9'h120);
    tick;
    a_req = 0;
    @(negedge clk);
    chk("cont_a_rvalid", a_rvalid, 1);
    chk("cont_a_rdata", a_rdata, 32'hA5A50120);
    chk("cont_c_rvalid", c_rvalid, 0);
    chk("cont_stall_gone", c_stall, 0);
    chk("cont_wait_clr", 32'(dut.wait_cnt_q), 0);
    tick;
    c_req = 0;
    a_req = 1; a_we = 1; a_addr = 9'h150; a_wdata = 32'h12345678;
    @(negedge clk);
    chk("aux_wr_gnt", a_gnt, 1);
    chk("aux_wr_mem", {mem_wr, mem_rd}, 2'b10);
    chk("aux_wr_data", mem_wr_data, 32'h12345678);
    tick;
    a_req = 0;
    c_req = 1; c_we = 0; c_addr = 9'h150;
    @(negedge clk);
    chk("aux_rb_gnt", c_gnt, 1);
    tick;
    c_req = 0;
    @(negedge clk);
    chk("aux_rb_data", c_rdata, 32'h12345678);
    tick;
    c_req = 1; c_addr = 9'h003;
    a_req = 1; a_we = 0; a_addr = 9'h002;
    tick; tick; tick;
    c_addr = 9'h001;
    @(negedge clk);
    chk("il_core_gnt", {c_gnt, a_gnt}, 2'b10);
    tick;
    @(negedge clk);
    chk("il_aux_gnt", {c_gnt, a_gnt, c_stall}, 3'b011);
    chk("il_c_rvalid", {c_rvalid, a_rvalid}, 2'b10);
    chk("il_c_rdata", c_rdata, 32'hA5A50001);
    tick;
    c_req = 0; a_req = 0;
    @(negedge clk);
    chk("il_a_rvalid", {c_rvalid, a_rvalid}, 2'b01);
    chk("il_a_rdata", a_rdata, 32'hA5A50002);
    chk("il_c_hold", c_rdata, 32'hA5A50001);
    tick;
    c_req = 1; c_addr = 9'h004;
    tick;
    reset = 0; c_req = 0;
    #1;
    chk("rst_rv", {c_rvalid, a_rvalid, a_err}, 0);
    chk("rst_rd", c_rdata | a_rdata, 0);
    chk("rst_mem", {c_gnt, a_gnt, mem_wr, mem_rd}, 0);
    tick;
    reset = 1;
    @(negedge clk);
    chk("rst_after", {c_rvalid, a_rvalid}, 0);
    tick;
    a_req = 1; a_we = 0; a_addr = 9'h050;
    @(negedge clk);
    chk("oob_gnt", a_gnt, 1);
`ifdef DMEM_ARB_BOUNDS_EN
    chk("oob_memrd", mem_rd, 0);
`else
    chk("oob_memrd", mem_rd, 1);
`endif
    tick;
    a_req = 0;
    @(negedge clk);
    chk("oob_rvalid", a_rvalid, 1);
`ifdef DMEM_ARB_BOUNDS_EN
    chk("oob_err", a_err, 1);
    chk("oob_rdata", a_rdata, 0);
`else
    chk("oob_err", a_err, 0);
    chk("oob_rdata", a_rdata, 32'hA5A50050);
`endif
    tick;
    @(negedge clk);
    chk("oob_err_pulse", {a_err, a_rvalid}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters: the core's MEM-stage load/store port and an auxiliary port used by the program loader or debug.
- The core has fixed priority. A starvation counter forces an aux grant after MAX_WAIT lost cycles, and the core is stalled for that cycle.
- Sits between the Datapath memory signals and the data memory, and returns read data to the requester that issued the read.

Parameters:
- DATA_W, 32, data word width
- ADDR_W, 9, word address width (512-entry data memory)
- MAX_WAIT, 4, consecutive lost cycles before an aux grant is forced; 0 gives aux fixed priority
- AUX_BASE, 9'h100, lowest aux-accessible address (used only with DMEM_ARB_BOUNDS_EN)
- AUX_LIMIT, 9'h1FF, highest aux-accessible address (used only with DMEM_ARB_BOUNDS_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core request accepted this cycle
- c_stall  out  1  c_req & ~c_gnt; freezes the pipeline
- c_rvalid  out  1  core read data valid (1-cycle pulse)
- c_rdata  out  DATA_W  core read data
- a_req, a_we, a_addr, a_wdata  in  1/1/ADDR_W/DATA_W  aux request fields
- a_gnt  out  1  aux request accepted this cycle
- a_rvalid  out  1  aux read data valid pulse
- a_rdata  out  DATA_W  aux read data
- a_err  out  1  aux access rejected (constant 0 without the macro)
- mem_wr, mem_rd  out  1  memory write/read strobes
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid 1 cycle after mem_rd

Behaviour:
- Reset (reset=0, asynchronous):
  - wait_cnt=0, rsp_pending=0, rsp_owner=CORE.
  - c_rvalid=a_rvalid=a_err=0; c_rdata=a_rdata=0.
  - Grant and memory strobes are combinational and are 0 while no request is present.
  - Reset during an outstanding read discards the response; no rvalid follows.
- Requester rule: req and its fields stay stable until the cycle gnt=1. Each granted request is one transfer.
- Arbitration (combinational, per cycle):
  - starve = (wait_cnt == MAX_WAIT)
  - a_gnt = a_req & (~c_req | starve)
  - c_gnt = c_req & ~a_gnt
  - Both requesting and not starve: core wins.
- Memory drive:
  - The winner's addr/wdata go to mem_addr/mem_wr_data.
  - mem_wr = gnt & we; mem_rd = gnt & ~we.
  - With no grant, all mem outputs are 0.
- wait_cnt (registered state):
  - +1 when a_req & ~a_gnt, saturating at MAX_WAIT.
  - Cleared when a_gnt=1 or a_req=0.
- Read return:
  - On a granted read, set rsp_pending=1 and rsp_owner=winner.
  - Next cycle: pulse the owner's rvalid and register mem_rd_data into the owner's rdata.
  - rdata holds between reads.
- Latency: one read result per cycle; a read may be issued while the previous read's data returns. Back-to-back reads give rvalid every cycle.
- Ordering: memory sees accesses in grant order. A write followed next cycle by a read of the same address returns the new data.
- Core stall: c_stall is high only in cycles where c_req=1 and aux wins, so at most one stall cycle per aux grant.

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_EN.
- With the macro defined, an aux access with a_addr outside [AUX_BASE, AUX_LIMIT]:
  - is granted (a_gnt=1) but no mem strobe is issued;
  - raises a_err as a registered 1-cycle pulse on the next cycle;
  - for a read, pulses a_rvalid with a_rdata=0 on that same next cycle.
- Without the macro: no address check; a_err is tied to 0.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum owner_e {OWNER_CORE, OWNER_AUX};
  - default-width localparams;
  - a mem_req_t struct {we, addr, wdata}.
- No sub-module is needed; the single module holds the arbitration and the response register.

Test Plan:
- Core only: core writes 0xDEADBEEF to address 0x010, then reads 0x010 -> c_gnt=1 both cycles, c_stall=0; c_rvalid one cycle after the read with c_rdata=0xDEADBEEF.
- Contention, MAX_WAIT=4: c_req held high, aux read of 0x120 -> aux granted in the 5th cycle; c_stall=1 only in that cycle; a_rvalid next cycle; wait_cnt returns to 0.
- Aux only: aux writes 0x12345678 to 0x150 with c_req=0 -> a_gnt in the same cycle; a later core read of 0x150 returns 0x12345678.
- Interleaved reads: core reads 0x001 then aux (starved) reads 0x002 on consecutive cycles -> c_rvalid and a_rvalid pulse on consecutive cycles with the correct data to each port and no crossover.
- Reset asserted the cycle after a granted read -> no rvalid; all outputs 0 until reset deasserts.
- With DMEM_ARB_BOUNDS_EN: aux read of 0x050 -> a_gnt=1, mem_rd=0; next cycle a_err=1, a_rvalid=1, a_rdata=0.
